// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the 640x480@60 VGA raster generator.
// Default values here feed the parameters of vga_scan_timing / vga_pix_divider.
package vga_timing_pkg;

  // Pixel clock divider default (50 MHz system clock -> 25 MHz pixel rate)
  localparam int CLK_DIV_DEF = 2;

  // Horizontal timing, in pixels
  localparam int H_VIS_DEF   = 640;
  localparam int H_FP_DEF    = 16;
  localparam int H_SYNC_DEF  = 96;
  localparam int H_BP_DEF    = 48;
  localparam int H_TOTAL_DEF = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  // Vertical timing, in lines
  localparam int V_VIS_DEF   = 480;
  localparam int V_FP_DEF    = 10;
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BP_DEF    = 33;
  localparam int V_TOTAL_DEF = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Sync pulse windows: start inclusive, end exclusive
  localparam int H_SYNC_START_DEF = H_VIS_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int V_SYNC_START_DEF = V_VIS_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  // Image windows: encrypted image (select 0) and decrypted image (select 1)
  localparam int ENC_W_DEF = 640;
  localparam int ENC_H_DEF = 320;
  localparam int DEC_W_DEF = 320;
  localparam int DEC_H_DEF = 320;

  // Vertical phase of the raster
  typedef enum logic [1:0] {
    V_ACT  = 2'd0,
    V_FP   = 2'd1,
    V_SYNC = 2'd2,
    V_BP   = 2'd3
  } vphase_t;

endpackage

// File: rtl/vga_pix_divider.sv
// Pixel-rate divider: div_cnt runs 0..CLK_DIV-1, and pix_tick is a registered
// one-clock pulse on the clock after div_cnt reaches its last value.
// With CLK_DIV=1 the tick is high on every clock outside reset.
module vga_pix_divider
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          pix_tick_q, pix_tick_d;

  // Next divider count and tick: wrap at the last count and raise the tick
  always_comb begin
    div_cnt_d  = div_cnt_q;
    pix_tick_d = 1'b0;
    if (div_cnt_q == CNT_LAST) begin
      div_cnt_d  = '0;
      pix_tick_d = 1'b1;
    end else begin
      div_cnt_d  = div_cnt_q + CNT_ONE;
      pix_tick_d = 1'b0;
    end
  end

  // Divider state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      pix_tick_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      pix_tick_q <= pix_tick_d;
    end
  end

  assign pix_tick = pix_tick_q;

endmodule

// File: rtl/vga_scan_timing.sv
// VGA raster timing: pixel counters, vertical phase FSM, registered sync /
// video / image-window decode and the frame-latched image select.
// All decoded outputs are computed from the next counter values, so they
// describe the same pixel as pos_x/pos_y on every clock.
// Optional feature: define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_scan_timing
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int H_VIS   = H_VIS_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_VIS   = V_VIS_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF,
  parameter int ENC_W   = ENC_W_DEF,
  parameter int ENC_H   = ENC_H_DEF,
  parameter int DEC_W   = DEC_W_DEF,
  parameter int DEC_H   = DEC_H_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        chg_img_in,
  output logic        pix_tick,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        in_image,
  output logic        chg_img,
`ifdef VGA_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic        frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS        = 10'(H_VIS);
  localparam logic [9:0] HS_START     = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END       = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] Y_FP_START   = 10'(V_VIS);
  localparam logic [9:0] Y_SYNC_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] Y_SYNC_END   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] ENC_W_X      = 10'(ENC_W);
  localparam logic [9:0] ENC_H_Y      = 10'(ENC_H);
  localparam logic [9:0] DEC_W_X      = 10'(DEC_W);
  localparam logic [9:0] DEC_H_Y      = 10'(DEC_H);

  logic       pix_tick_s;
  logic [9:0] pos_x_q, pos_x_d;
  logic [9:0] pos_y_q, pos_y_d;
  vphase_t    vphase_q, vphase_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       in_image_q, in_image_d;
  logic       chg_img_q, chg_img_d;
  logic       frame_start_q, frame_start_d;
  logic [9:0] img_w_s, img_h_s;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
`endif

  vga_pix_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (pix_tick_s)
  );

  // Next raster position, vertical phase and decoded outputs for the next pixel
  always_comb begin
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    vphase_d      = vphase_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    in_image_d    = in_image_q;
    chg_img_d     = chg_img_q;
    frame_start_d = 1'b0;
    img_w_s       = ENC_W_X;
    img_h_s       = ENC_H_Y;
    if (pix_tick_s) begin
      if (pos_x_q == X_LAST) begin
        pos_x_d = 10'd0;
        if (pos_y_q == Y_LAST) begin
          pos_y_d = 10'd0;
        end else begin
          pos_y_d = pos_y_q + 10'd1;
        end
        // Phase changes only on line wrap, when the new line crosses a boundary
        case (vphase_q)
          vga_timing_pkg::V_ACT:
            vphase_d = (pos_y_d == Y_FP_START)   ? vga_timing_pkg::V_FP   : vga_timing_pkg::V_ACT;
          vga_timing_pkg::V_FP:
            vphase_d = (pos_y_d == Y_SYNC_START) ? vga_timing_pkg::V_SYNC : vga_timing_pkg::V_FP;
          vga_timing_pkg::V_SYNC:
            vphase_d = (pos_y_d == Y_SYNC_END)   ? vga_timing_pkg::V_BP   : vga_timing_pkg::V_SYNC;
          vga_timing_pkg::V_BP:
            vphase_d = (pos_y_d == 10'd0)        ? vga_timing_pkg::V_ACT  : vga_timing_pkg::V_BP;
          default:
            vphase_d = vga_timing_pkg::V_BP;
        endcase
      end else begin
        pos_x_d = pos_x_q + 10'd1;
      end

      // The image select only moves at the (0,0) boundary so a frame never tears
      if ((pos_x_d == 10'd0) && (pos_y_d == 10'd0)) begin
        frame_start_d = 1'b1;
        chg_img_d     = chg_img_in;
      end else begin
        frame_start_d = 1'b0;
        chg_img_d     = chg_img_q;
      end

      if (chg_img_d) begin
        img_w_s = DEC_W_X;
        img_h_s = DEC_H_Y;
      end else begin
        img_w_s = ENC_W_X;
        img_h_s = ENC_H_Y;
      end

      hsync_d    = !((pos_x_d >= HS_START) && (pos_x_d < HS_END));
      vsync_d    = (vphase_d != vga_timing_pkg::V_SYNC);
      video_on_d = (pos_x_d < X_VIS) && (vphase_d == vga_timing_pkg::V_ACT);
      in_image_d = video_on_d && (pos_x_d < img_w_s) && (pos_y_d < img_h_s);
    end else begin
      frame_start_d = 1'b0;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Frame counter advances with each frame start and wraps naturally
  always_comb begin
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Frame counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  // Raster state and vertical FSM; reset parks at the last pixel so the first tick starts a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x_q       <= X_LAST;
      pos_y_q       <= Y_LAST;
      vphase_q      <= vga_timing_pkg::V_BP;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      in_image_q    <= 1'b0;
      chg_img_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      vphase_q      <= vphase_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      in_image_q    <= in_image_d;
      chg_img_q     <= chg_img_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_tick    = pix_tick_s;
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign in_image    = in_image_q;
  assign chg_img     = chg_img_q;
  assign frame_start = frame_start_q;

endmodule
